// File: rtl/accum_seq_pkg.sv
// Shared definitions for the sequential accumulator: state encoding and the
// counter-width helper.
package accum_seq_pkg;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Bits needed to count 0..v-1, never less than one so a COUNT of 1 still
   // gets a real register.
   function automatic int clog2_min1(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/accum_seq_add_n.sv
// N-bit ripple-carry adder built from a chain of full-adder cells; the sum is
// the LUT part of each cell and the majority term is the carry link.
module add_n #(
   parameter int N = 8
) (
   input  logic [N-1:0] I0,
   input  logic [N-1:0] I1,
   input  logic         CIN,
   output logic [N-1:0] O,
   output logic         COUT
);

   logic [N:0] carry;

   assign carry[0] = CIN;

   for (genvar k = 0; k < N; k++) begin : g_cell
      assign O[k]       = I0[k] ^ I1[k] ^ carry[k];
      assign carry[k+1] = (I0[k] & I1[k]) | (I0[k] & carry[k]) | (I1[k] & carry[k]);
   end

   assign COUT = carry[N];

endmodule

// File: rtl/accum_seq.sv
// Sums COUNT operands through the ripple adder and hands the result, with a
// sticky carry-out flag, to a valid/ready consumer.
module accum_seq
   import accum_seq_pkg::*;
#(
   parameter int N     = 8,
   parameter int COUNT = 4
) (
   input  logic         CLKIN,
   input  logic         RESET,
   input  logic         CLR,
   input  logic [N-1:0] I,
   input  logic         IVALID,
   output logic         IREADY,
   output logic [N-1:0] O,
   output logic         OVF,
   output logic         OVALID,
   input  logic         OREADY
);

   localparam int            CW   = clog2_min1(COUNT);
   localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

   state_e        state_q;
   logic [N-1:0]  acc_q;
   logic          ovf_q;
   logic [CW-1:0] cnt_q;

   logic [N-1:0]  sum;
   logic          cout;

   add_n #(.N(N)) u_add (
      .I0   (acc_q),
      .I1   (I),
      .CIN  (1'b0),
      .O    (sum),
      .COUT (cout)
   );

   // CLR outranks both the operand transfer and the result handoff.
   always_ff @(posedge CLKIN or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (CLR) begin
         state_q <= ST_ACC;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_ACC: begin
               if (IVALID) begin
                  acc_q <= sum;
                  ovf_q <= ovf_q | cout;
                  if (cnt_q == LAST) begin
                     cnt_q   <= '0;
                     state_q <= ST_HOLD;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
            end
            ST_HOLD: begin
               if (OREADY) begin
                  acc_q   <= '0;
                  ovf_q   <= 1'b0;
                  state_q <= ST_ACC;
               end
            end
            default: state_q <= ST_ACC;
         endcase
      end
   end

   assign O      = acc_q;
   assign OVF    = ovf_q;
   assign IREADY = (state_q == ST_ACC);
   assign OVALID = (state_q == ST_HOLD);

endmodule

// File: tb/tb_accum_seq.sv
// Directed bench for accum_seq: an N=8/COUNT=4 instance and an N=4/COUNT=1
// instance sharing clock and reset.
module tb_accum_seq;

   logic       clk;
   logic       rst;

   logic       a_clr, a_iv, a_ir, a_ovf, a_ov, a_or;
   logic [7:0] a_i, a_o;

   logic       b_clr, b_iv, b_ir, b_ovf, b_ov, b_or;
   logic [3:0] b_i, b_o;

   int checks = 0;
   int errors = 0;

   accum_seq #(.N(8), .COUNT(4)) dut_a (
      .CLKIN(clk), .RESET(rst), .CLR(a_clr), .I(a_i), .IVALID(a_iv), .IREADY(a_ir),
      .O(a_o), .OVF(a_ovf), .OVALID(a_ov), .OREADY(a_or)
   );

   accum_seq #(.N(4), .COUNT(1)) dut_b (
      .CLKIN(clk), .RESET(rst), .CLR(b_clr), .I(b_i), .IVALID(b_iv), .IREADY(b_ir),
      .O(b_o), .OVF(b_ovf), .OVALID(b_ov), .OREADY(b_or)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_a(input logic [7:0] v);
      a_i  = v;
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
   endtask

   task automatic chk_a(input string tag, input logic [7:0] o, input logic ovf,
                        input logic ov, input logic ir);
      chk({tag, ".O"}, a_o, o);
      chk({tag, ".OVF"}, a_ovf, ovf);
      chk({tag, ".OVALID"}, a_ov, ov);
      chk({tag, ".IREADY"}, a_ir, ir);
   endtask

   logic       m_hold;
   logic [3:0] m_o;
   logic       iv;
   logic [3:0] v;

   initial begin
      rst = 1'b1;
      a_clr = 1'b0; a_iv = 1'b0; a_i = '0; a_or = 1'b1;
      b_clr = 1'b0; b_iv = 1'b0; b_i = '0; b_or = 1'b1;
      #1;
      chk_a("reset", 8'd0, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      rst = 1'b0;

      // basic sum 1+2+3+4
      feed_a(8'd1); feed_a(8'd2); feed_a(8'd3);
      chk_a("sum3", 8'd6, 1'b0, 1'b0, 1'b1);
      feed_a(8'd4);
      chk_a("sum_res", 8'd10, 1'b0, 1'b1, 1'b0);
      tick();
      chk_a("sum_taken", 8'd0, 1'b0, 1'b0, 1'b1);

      // wrap: 200+100 carries, result 45 with OVF
      feed_a(8'd200); feed_a(8'd100);
      chk_a("wrap2", 8'd44, 1'b1, 1'b0, 1'b1);
      feed_a(8'd0); feed_a(8'd1);
      chk_a("wrap_res", 8'd45, 1'b1, 1'b1, 1'b0);
      tick();
      chk_a("wrap_taken", 8'd0, 1'b0, 1'b0, 1'b1);
      feed_a(8'd1); feed_a(8'd1); feed_a(8'd1); feed_a(8'd1);
      chk_a("after_wrap", 8'd4, 1'b0, 1'b1, 1'b0);
      tick();

      // backpressure, IVALID pulses ignored while holding
      a_or = 1'b0;
      feed_a(8'd3); feed_a(8'd3); feed_a(8'd3); feed_a(8'd3);
      chk_a("bp_res", 8'd12, 1'b0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         a_i  = 8'd7;
         a_iv = k[0];
         tick();
         chk_a("bp_hold", 8'd12, 1'b0, 1'b1, 1'b0);
      end
      a_iv = 1'b0;
      a_or = 1'b1;
      tick();
      chk_a("bp_taken", 8'd0, 1'b0, 1'b0, 1'b1);
      feed_a(8'd1); feed_a(8'd1); feed_a(8'd1); feed_a(8'd1);
      chk_a("bp_next", 8'd4, 1'b0, 1'b1, 1'b0);
      tick();

      // CLR mid-accumulation beats a simultaneous operand
      feed_a(8'd5); feed_a(8'd6);
      chk_a("clr_pre", 8'd11, 1'b0, 1'b0, 1'b1);
      a_clr = 1'b1; a_i = 8'd9; a_iv = 1'b1;
      tick();
      a_clr = 1'b0; a_iv = 1'b0;
      chk_a("clr", 8'd0, 1'b0, 1'b0, 1'b1);
      feed_a(8'd1); feed_a(8'd1); feed_a(8'd1);
      chk_a("clr_cnt", 8'd3, 1'b0, 1'b0, 1'b1);
      feed_a(8'd1);
      chk_a("clr_res", 8'd4, 1'b0, 1'b1, 1'b0);
      tick();

      // async reset mid-stream, checked before the next edge
      feed_a(8'd7); feed_a(8'd8);
      chk_a("rst_pre", 8'd15, 1'b0, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1 chk_a("rst_mid", 8'd0, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
      // async reset while holding a result
      a_or = 1'b0;
      feed_a(8'd2); feed_a(8'd2); feed_a(8'd2); feed_a(8'd2);
      chk_a("rst_hold_pre", 8'd8, 1'b0, 1'b1, 1'b0);
      #2 rst = 1'b1;
      #1 chk_a("rst_hold", 8'd0, 1'b0, 1'b0, 1'b1);
      tick();
      rst = 1'b0;
      a_or = 1'b1;
      feed_a(8'd1); feed_a(8'd1); feed_a(8'd1); feed_a(8'd1);
      chk_a("rst_after", 8'd4, 1'b0, 1'b1, 1'b0);
      tick();

      // COUNT=1, N=4: each transfer is a result
      b_i = 4'd15; b_iv = 1'b1;
      tick();
      b_iv = 1'b0;
      chk("c1_r1.O", b_o, 4'd15);
      chk("c1_r1.OVF", b_ovf, 1'b0);
      chk("c1_r1.OVALID", b_ov, 1'b1);
      tick();
      chk("c1_gap.OVALID", b_ov, 1'b0);
      b_i = 4'd15; b_iv = 1'b1;
      tick();
      b_iv = 1'b0;
      chk("c1_r2.O", b_o, 4'd15);
      chk("c1_r2.OVF", b_ovf, 1'b0);
      chk("c1_r2.OVALID", b_ov, 1'b1);
      tick();
      chk("c1_idle.IREADY", b_ir, 1'b1);

      // random IVALID gaps against a cycle model of the handshake
      m_hold = 1'b0;
      m_o    = 4'd0;
      for (int c = 0; c < 60; c++) begin
         iv   = ($urandom_range(0, 2) != 0);
         v    = 4'($urandom_range(0, 15));
         b_iv = iv;
         b_i  = v;
         if (m_hold) begin
            m_hold = 1'b0;
            m_o    = 4'd0;
         end else if (iv) begin
            m_hold = 1'b1;
            m_o    = v;
         end
         tick();
         chk("sb.O", b_o, m_o);
         chk("sb.OVALID", b_ov, m_hold);
         chk("sb.OVF", b_ovf, 1'b0);
      end
      b_iv = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
